// File: rtl/time_pkg.sv
// time_pkg: shared constants and types for the time-register read/load path.
//   - Register address map (seconds / minutes / hours / status).
//   - Field widths of the live counters.
//   - Read-back FSM state encoding.
package time_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

  localparam logic [1:0] ADDR_SEC  = 2'b00;
  localparam logic [1:0] ADDR_MIN  = 2'b01;
  localparam logic [1:0] ADDR_HOUR = 2'b10;
  localparam logic [1:0] ADDR_STAT = 2'b11;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/time_reader_if.sv
// time_reader_if: host-side bus of the time read-back port.
//   load     : time-register load strobe (only observed by the reader)
//   rd_en    : read request, one read per asserted cycle
//   addrs    : register address, sampled with rd_en
//   data_out : registered read data
//   rd_valid : one-cycle pulse per read, in the cycle after rd_en is sampled
//   locked   : a coherent snapshot is currently held
//
// Handshake: rd_en acts as a valid with no ready -- the reader accepts a read
// on every cycle rd_en is high. Each accepted read produces exactly one
// rd_valid pulse one cycle later; consecutive reads give a continuous
// rd_valid. Without rd_en, data_out holds its last value.
interface time_reader_if;
  import time_pkg::*;

  logic       load;
  logic       rd_en;
  logic [1:0] addrs;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       locked;

  modport master (
    output load, rd_en, addrs,
    input  data_out, rd_valid, locked
  );

  modport slave (
    input  load, rd_en, addrs,
    output data_out, rd_valid, locked
  );

endinterface

// File: rtl/time_bin2bcd.sv
// time_bin2bcd: combinational 6-bit binary (0..59) to two-digit packed BCD.
//   bin : binary value, 0..59
//   bcd : tens digit in [7:4], units digit in [3:0]
// The tens digit is found by a short compare cascade, which is cheap for a
// range this small and avoids a general divider.
module time_bin2bcd (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [2:0] tens;
  logic [3:0] units;

  always_comb begin
    tens  = 3'd0;
    units = bin[3:0];
    if (bin >= 6'd50) begin
      tens  = 3'd5;
      units = 4'(bin - 6'd50);
    end else if (bin >= 6'd40) begin
      tens  = 3'd4;
      units = 4'(bin - 6'd40);
    end else if (bin >= 6'd30) begin
      tens  = 3'd3;
      units = 4'(bin - 6'd30);
    end else if (bin >= 6'd20) begin
      tens  = 3'd2;
      units = 4'(bin - 6'd20);
    end else if (bin >= 6'd10) begin
      tens  = 3'd1;
      units = 4'(bin - 6'd10);
    end
    bcd = {1'b0, tens, units};
  end

endmodule

// File: rtl/time_reader.sv
// time_reader: read-back port for the real-time clock counters.
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   tc_time_base : one-second tick that advances the counters
//   q_seconds/q_minutes/q_hours : live counter values
//   bus          : host bus (time_reader_if.slave)
//   state_dbg    : current read-back FSM state
//
// A seconds read snapshots all three counters so a seconds->minutes->hours
// burst stays coherent across a rollover; the hours read ends the burst.
// The stale flag records that the counters may have moved since the snapshot.
//
// Build option: define TIME_READER_BCD_EN to return time fields as packed BCD;
// otherwise they are plain binary, zero-extended.
module time_reader
  import time_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tc_time_base,
  input  logic [SEC_W-1:0]  q_seconds,
  input  logic [MIN_W-1:0]  q_minutes,
  input  logic [HOUR_W-1:0] q_hours,
  time_reader_if.slave      bus,
  output state_t            state_dbg
);

  state_t            state, state_nxt;
  logic              locked_w;
  logic [SEC_W-1:0]  snap_s;
  logic [MIN_W-1:0]  snap_m;
  logic [HOUR_W-1:0] snap_h;
  logic              stale;
  logic [7:0]        data_q;
  logic              valid_q;
  logic [5:0]        sel_val;
  logic              is_stat;
  logic [7:0]        status;
  logic [7:0]        rd_word;
  logic              sec_rd;

  assign sec_rd = bus.rd_en && (bus.addrs == ADDR_SEC);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM: next state. A seconds read (re)starts a burst from either state.
  always_comb begin
    state_nxt = state;
    if (bus.rd_en) begin
      case (bus.addrs)
        ADDR_SEC:  state_nxt = ST_LOCKED;
        ADDR_HOUR: if (state == ST_LOCKED) state_nxt = ST_IDLE;
        default:   state_nxt = state;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    locked_w  = (state == ST_LOCKED);
    state_dbg = state;
  end

  // Read mux. Seconds always come from the live counter: the snapshot is
  // taken on this same read, so the live value is the snapshot value.
  always_comb begin
    sel_val = '0;
    is_stat = 1'b0;
    case (bus.addrs)
      ADDR_SEC:  sel_val = q_seconds;
      ADDR_MIN:  sel_val = locked_w ? snap_m : q_minutes;
      ADDR_HOUR: sel_val = locked_w ? {1'b0, snap_h} : {1'b0, q_hours};
      default:   is_stat = 1'b1;
    endcase
    status = {stale, locked_w, 6'b0};
  end

`ifdef TIME_READER_BCD_EN
  logic [7:0] bcd_val;

  time_bin2bcd u_bin2bcd (
    .bin (sel_val),
    .bcd (bcd_val)
  );

  assign rd_word = is_stat ? status : bcd_val;
`else
  assign rd_word = is_stat ? status : {2'b00, sel_val};
`endif

  // Snapshot, stale flag and registered read response. stale is captured
  // as tc|load on the snapshot edge because the counters may change on that
  // very edge; it survives the return to IDLE so the host can still read it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_s  <= '0;
      snap_m  <= '0;
      snap_h  <= '0;
      stale   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.rd_en;
      if (bus.rd_en) data_q <= rd_word;
      if (sec_rd) begin
        snap_s <= q_seconds;
        snap_m <= q_minutes;
        snap_h <= q_hours;
        stale  <= tc_time_base | bus.load;
      end else if (locked_w && (tc_time_base || bus.load)) begin
        stale <= 1'b1;
      end
    end
  end

  assign bus.data_out = data_q;
  assign bus.rd_valid = valid_q;
  assign bus.locked   = locked_w;

endmodule
